// File: rtl/lcd_feeder_pkg.sv
// lcd_feeder_pkg
// Shared definitions for the LCD character feeder: the feeder FSM state
// encoding, the ASCII control codes the CRLF filter looks at, and the
// default sizing constants used by lcd_char_feeder.
`timescale 1ns/1ps
package lcd_feeder_pkg;

   // IDLE waits for data and a ready controller, PRESENT issues the strobe,
   // WAIT_ACK waits for the controller to drop ready, WAIT_READY waits for
   // it to come back before the next character can be offered.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESENT    = 2'd1,
      WAIT_ACK   = 2'd2,
      WAIT_READY = 2'd3
   } feeder_state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam int DEFAULT_DEPTH       = 16;
   localparam int DEFAULT_ADDR_W      = 4;
   localparam int DEFAULT_ACK_TIMEOUT = 255;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on rdata_o; pop_i retires it. Push and pop may happen in the
// same cycle, including when the FIFO is full.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write request; ignored when full unless popping too
//   wdata_i  in   write data
//   pop_i    in   read request; ignored when empty
//   rdata_o  out  current head entry
//   count_o  out  occupancy, 0..DEPTH
//   full_o   out  occupancy == DEPTH
//   empty_o  out  occupancy == 0
`timescale 1ns/1ps
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  rdata_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              doPush, doPop;

   assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rdPtr_q];

   // A push into a full FIFO is only legal when the head leaves in the same
   // cycle; the write then lands in the slot the head is vacating. Pointers
   // are ADDR_W bits wide so they wrap modulo DEPTH on their own.
   always_comb begin
      doPop   = pop_i && !empty_o;
      doPush  = push_i && (!full_o || doPop);
      wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + 1'b1;
      end else if (doPop && !doPush) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage has no reset: stale entries are never visible because the
   // occupancy count gates every read.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/lcd_char_feeder.sv
// lcd_char_feeder
// Buffers bytes from the UART receiver and offers them one at a time to the
// LCD controller using its ready/valid handshake. A character is offered
// with a one-cycle o_Data_Valid strobe; the controller accepts it by
// dropping i_Display_Ready. If the controller never drops ready within
// ACK_TIMEOUT cycles, the same character is offered again.
//
// Ports:
//   clock             in   rising-edge clock
//   reset             in   synchronous active-high reset
//   i_Rx_DV           in   UART byte-valid strobe
//   i_Rx_Byte         in   UART byte
//   i_Display_Ready   in   controller can accept a character
//   i_Clear_Overflow  in   clears the sticky overflow flag
//   o_Data_Valid      out  one-cycle character strobe
//   o_Data_Character  out  character, held from strobe to next strobe
//   o_Fifo_Count      out  FIFO occupancy
//   o_Overflow        out  sticky: a byte was dropped on a full FIFO
//   o_Busy            out  FIFO non-empty or handshake in progress
//
// Build option: define LCD_CRLF_COLLAPSE_EN to discard an LF that directly
// follows an accepted CR, so CRLF line endings clear the display only once.
`timescale 1ns/1ps
module lcd_char_feeder
   import lcd_feeder_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_Rx_DV,
   input  logic [7:0]        i_Rx_Byte,
   input  logic              i_Display_Ready,
   input  logic              i_Clear_Overflow,
   output logic              o_Data_Valid,
   output logic [7:0]        o_Data_Character,
   output logic [ADDR_W:0]   o_Fifo_Count,
   output logic              o_Overflow,
   output logic              o_Busy
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   feeder_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        char_q, char_d;
   logic              valid_q, valid_d;
   logic              overflow_q, overflow_d;

   logic              fifoPop;
   logic              fifoFull, fifoEmpty;
   logic [7:0]        fifoHead;
   logic [ADDR_W:0]   fifoCount;

   logic              collapse;
   logic              wantPush;
   logic              dropByte;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (8)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (wantPush),
      .wdata_i (i_Rx_Byte),
      .pop_i   (fifoPop),
      .rdata_o (fifoHead),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

`ifdef LCD_CRLF_COLLAPSE_EN
   logic lastCr_q, lastCr_d;

   // Track whether the most recent byte seen on the write side was a CR
   // that went into the FIFO. A collapsed LF clears the flag, so a second
   // LF in a row is kept. Bytes dropped on overflow leave it untouched.
   always_comb begin
      collapse = lastCr_q && (i_Rx_Byte == ASCII_LF);
      lastCr_d = lastCr_q;
      if (i_Rx_DV) begin
         if (collapse) begin
            lastCr_d = 1'b0;
         end else if (!fifoFull || fifoPop) begin
            lastCr_d = (i_Rx_Byte == ASCII_CR);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lastCr_q <= 1'b0;
      end else begin
         lastCr_q <= lastCr_d;
      end
   end
`else
   assign collapse = 1'b0;
`endif

   // Write side: a byte is dropped only when the FIFO is full and the head
   // is not leaving this cycle. A new drop wins over a simultaneous clear.
   always_comb begin
      wantPush   = i_Rx_DV && !collapse;
      dropByte   = wantPush && fifoFull && !fifoPop;
      overflow_d = overflow_q;
      if (dropByte) begin
         overflow_d = 1'b1;
      end else if (i_Clear_Overflow) begin
         overflow_d = 1'b0;
      end
   end

   // Handshake FSM. The character is latched when leaving IDLE so it is
   // already stable when the strobe appears. The strobe itself is
   // registered, so it shows up in the first WAIT_ACK cycle. If ready has
   // vanished by the time PRESENT runs, no strobe is issued and the FSM
   // falls back to IDLE, which keeps the strobe away from a busy controller.
   // The head is only popped once the controller acknowledges by dropping
   // ready; a timeout returns to IDLE with the head still in place.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      char_d  = char_q;
      valid_d = 1'b0;
      fifoPop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifoEmpty && i_Display_Ready) begin
               char_d  = fifoHead;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (i_Display_Ready) begin
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_ACK: begin
            if (!i_Display_Ready) begin
               fifoPop = 1'b1;
               state_d = WAIT_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_READY: begin
            if (i_Display_Ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight character.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         char_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         char_q     <= char_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_Data_Valid     = valid_q;
   assign o_Data_Character = char_q;
   assign o_Fifo_Count     = fifoCount;
   assign o_Overflow       = overflow_q;
   assign o_Busy           = !fifoEmpty || (state_q != IDLE);

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb_lcd_char_feeder
// Directed bench for lcd_char_feeder. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the
// rising edge that produced them. The LCD controller is modelled inline:
// it waits for a strobe, drops ready for a fixed number of cycles, then
// raises it again. Expected values follow LCD_CRLF_COLLAPSE_EN if defined.
`timescale 1ns/1ps
module tb_lcd_char_feeder;

   localparam int DEPTH       = 16;
   localparam int ADDR_W      = 4;
   localparam int ACK_TIMEOUT = 255;

   logic              clock = 1'b0;
   logic              reset;
   logic              rxDv;
   logic [7:0]        rxByte;
   logic              ready;
   logic              clrOvf;
   logic              dataValid;
   logic [7:0]        dataChar;
   logic [ADDR_W:0]   fifoCount;
   logic              overflow;
   logic              busy;

   int                assertCount = 0;
   int                failCount   = 0;
   logic [7:0]        expChars[$];

   typedef struct {
      logic            dv;
      logic [7:0]      data;
      logic            clr;
      logic [ADDR_W:0] expCount;
      logic            expOvf;
   } vec_t;

   vec_t vecs[20];

   lcd_char_feeder #(
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .i_Rx_DV          (rxDv),
      .i_Rx_Byte        (rxByte),
      .i_Display_Ready  (ready),
      .i_Clear_Overflow (clrOvf),
      .o_Data_Valid     (dataValid),
      .o_Data_Character (dataChar),
      .o_Fifo_Count     (fifoCount),
      .o_Overflow       (overflow),
      .o_Busy           (busy)
   );

   // 10 ns clock.
   always #5 clock = ~clock;

   // Hard stop in case something in the bench itself stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at a falling edge and return at the next
   // falling edge, with strobes returned low.
   task automatic applyStimulus(input logic dv, input logic [7:0] b,
                                input logic rdy, input logic clr);
      rxDv   = dv;
      rxByte = b;
      ready  = rdy;
      clrOvf = clr;
      @(negedge clock);
      rxDv   = 1'b0;
      clrOvf = 1'b0;
   endtask

   task automatic doReset();
      rxDv   = 1'b0;
      rxByte = 8'h00;
      clrOvf = 1'b0;
      ready  = 1'b0;
      reset  = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset  = 1'b0;
   endtask

   // Wait for a strobe at the current or a later falling edge.
   task automatic waitValid(input int limit, output logic found, output int cycles);
      found  = 1'b0;
      cycles = 0;
      for (int c = 0; c < limit; c++) begin
         if (dataValid) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
         cycles++;
      end
   endtask

   // Controller model: for each expected character wait for the strobe,
   // compare it, drop ready for holdCycles, raise ready again. Afterwards
   // make sure nothing else is offered and the FIFO has drained.
   task automatic collectChars(input int holdCycles, input string tag);
      logic found;
      int   cycles;
      int   badValid;
      int   extraValid;
      badValid   = 0;
      extraValid = 0;
      ready      = 1'b1;
      for (int k = 0; k < expChars.size(); k++) begin
         waitValid(64, found, cycles);
         if (!found) begin
            checkOutput({tag, " strobe timeout"}, 32'd0, 32'd1);
            return;
         end
         checkOutput({tag, " character"}, dataChar, expChars[k]);
         ready = 1'b0;
         for (int h = 0; h < holdCycles; h++) begin
            @(negedge clock);
            if (dataValid) badValid++;
         end
         ready = 1'b1;
      end
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (dataValid) extraValid++;
      end
      checkOutput({tag, " strobe while not ready"}, badValid, 0);
      checkOutput({tag, " extra strobes"}, extraValid, 0);
      checkOutput({tag, " final count"}, fifoCount, 0);
      checkOutput({tag, " final busy"}, busy, 0);
   endtask

   initial begin
      logic found;
      int   cycles;

      // Overflow/clear vectors with ready held low: fill, overflow, clear,
      // clear racing a drop (drop wins), clear again.
      for (int i = 0; i < 16; i++) begin
         vecs[i] = '{dv: 1'b1, data: 8'(8'h60 + i), clr: 1'b0,
                     expCount: 5'(i + 1), expOvf: 1'b0};
      end
      vecs[16] = '{dv: 1'b1, data: 8'h70, clr: 1'b0, expCount: 5'd16, expOvf: 1'b1};
      vecs[17] = '{dv: 1'b0, data: 8'h00, clr: 1'b1, expCount: 5'd16, expOvf: 1'b0};
      vecs[18] = '{dv: 1'b1, data: 8'h71, clr: 1'b1, expCount: 5'd16, expOvf: 1'b1};
      vecs[19] = '{dv: 1'b0, data: 8'h00, clr: 1'b1, expCount: 5'd16, expOvf: 1'b0};

      @(negedge clock);
      doReset();

      checkOutput("reset valid", dataValid, 0);
      checkOutput("reset character", dataChar, 8'h00);
      checkOutput("reset count", fifoCount, 0);
      checkOutput("reset overflow", overflow, 0);
      checkOutput("reset busy", busy, 0);

      // Single byte with ready high: strobe in the third cycle after the
      // edge that samples i_Rx_DV.
      ready = 1'b1;
      @(negedge clock);
      applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
      checkOutput("single cycle1 valid", dataValid, 0);
      checkOutput("single cycle1 count", fifoCount, 1);
      @(negedge clock);
      checkOutput("single cycle2 valid", dataValid, 0);
      @(negedge clock);
      checkOutput("single cycle3 valid", dataValid, 1);
      checkOutput("single character", dataChar, 8'h41);
      ready = 1'b0;
      @(negedge clock);
      checkOutput("single after ack valid", dataValid, 0);
      checkOutput("single after ack count", fifoCount, 0);
      checkOutput("single after ack busy", busy, 1);
      checkOutput("single character held", dataChar, 8'h41);
      ready = 1'b1;
      @(negedge clock);
      checkOutput("single idle busy", busy, 0);

      // Burst while the controller is busy, then drain in order.
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      end
      checkOutput("burst count", fifoCount, 10);
      checkOutput("burst valid", dataValid, 0);
      checkOutput("burst busy", busy, 1);
      expChars.delete();
      for (int i = 0; i < 10; i++) expChars.push_back(8'(8'h30 + i));
      collectChars(14, "burst");

      // Overflow table, then drain: dropped bytes must never appear.
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].dv, vecs[i].data, 1'b0, vecs[i].clr);
         checkOutput($sformatf("ovf vec%0d count", i), fifoCount, vecs[i].expCount);
         checkOutput($sformatf("ovf vec%0d overflow", i), overflow, vecs[i].expOvf);
         checkOutput($sformatf("ovf vec%0d valid", i), dataValid, 0);
      end
      expChars.delete();
      for (int i = 0; i < 16; i++) expChars.push_back(8'(8'h60 + i));
      collectChars(3, "overflow drain");

      // Timeout retry: ready never drops, the same byte is offered again
      // after the acknowledge window expires, and it is never popped.
      doReset();
      ready = 1'b1;
      @(negedge clock);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
      waitValid(8, found, cycles);
      checkOutput("retry first strobe seen", found, 1);
      checkOutput("retry first character", dataChar, 8'h55);
      @(negedge clock);
      waitValid(400, found, cycles);
      cycles = cycles + 1;
      checkOutput("retry second strobe seen", found, 1);
      checkOutput("retry gap in window",
                  (cycles >= ACK_TIMEOUT + 1) && (cycles <= ACK_TIMEOUT + 3), 1);
      checkOutput("retry second character", dataChar, 8'h55);
      checkOutput("retry count", fifoCount, 1);

      // Reset while waiting for the acknowledge with five bytes queued.
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      end
      ready = 1'b1;
      waitValid(8, found, cycles);
      checkOutput("midreset strobe seen", found, 1);
      checkOutput("midreset count before", fifoCount, 5);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("midreset count", fifoCount, 0);
      checkOutput("midreset valid", dataValid, 0);
      checkOutput("midreset character", dataChar, 8'h00);
      checkOutput("midreset overflow", overflow, 0);
      checkOutput("midreset busy", busy, 0);
      @(negedge clock);
      @(negedge clock);
      checkOutput("midreset stays idle", busy, 0);

      // CR LF LF sequence.
      doReset();
      applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
      expChars.delete();
`ifdef LCD_CRLF_COLLAPSE_EN
      checkOutput("crlf count", fifoCount, 2);
      expChars.push_back(8'h0D);
      expChars.push_back(8'h0A);
`else
      checkOutput("crlf count", fifoCount, 3);
      expChars.push_back(8'h0D);
      expChars.push_back(8'h0A);
      expChars.push_back(8'h0A);
`endif
      checkOutput("crlf overflow", overflow, 0);
      collectChars(3, "crlf");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/lcd_char_feeder.md
Name: lcd_char_feeder

Overview:
- Producer end of the LCD controller's character interface: buffers bytes from the UART receiver and hands them to the LCD controller one at a time under its ready/valid handshake.
- Sits between the UART RX (valid pulse + byte) and the LCD controller (display-ready out, data-valid/character in).
- Absorbs bursts arriving while the controller is busy with clear, shift or write timing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 255, cycles to wait for the controller to drop ready after a valid pulse before re-presenting the byte.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_Rx_DV  in  1  one-cycle strobe from the UART receiver: byte valid.
- i_Rx_Byte  in  8  received byte.
- i_Display_Ready  in  1  high while the LCD controller can accept a character.
- i_Clear_Overflow  in  1  one-cycle pulse; clears o_Overflow.
- o_Data_Valid  out  1  one-cycle character strobe to the LCD controller.
- o_Data_Character  out  8  character; stable from the strobe until the next strobe.
- o_Fifo_Count  out  ADDR_W+1  current FIFO occupancy.
- o_Overflow  out  1  sticky: a byte was dropped.
- o_Busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. A reset mid-transfer discards the FIFO and any in-flight byte.
- FIFO write: on i_Rx_DV when not full. Push and pop in the same cycle are both allowed, including when full; count is unchanged.
- Full with no pop: the byte is dropped and o_Overflow is set next cycle.
- o_Overflow: cleared by i_Clear_Overflow. If a clear and a new drop occur in the same cycle, the set wins.
- Read side is first-word-fall-through; the head is visible the cycle after the write.
- FSM states: IDLE, PRESENT, WAIT_ACK, WAIT_READY.
- IDLE: if count>0 and i_Display_Ready=1, load o_Data_Character<=head and go to PRESENT. Otherwise stay.
- PRESENT: o_Data_Valid=1 for exactly this cycle. Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - i_Display_Ready=0 means accept: pop the head and go to WAIT_READY.
  - Else increment the counter. When it reaches ACK_TIMEOUT, go to IDLE with no pop; the same byte is re-presented.
- WAIT_READY: when i_Display_Ready=1, go to IDLE. The next valid can therefore be no earlier than 2 cycles after ready rises.
- Latency: i_Rx_DV sampled at edge N with FIFO empty, FSM IDLE and ready high gives o_Data_Valid high in the cycle after edge N+2.
- o_Data_Valid is never asserted while i_Display_Ready=0, and never on consecutive cycles.
- Byte values: CR/LF and all other values are passed through unaltered. Character remapping and line clearing belong to the LCD controller.
- Width rule: the count saturates at DEPTH and does not wrap. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: LCD_CRLF_COLLAPSE_EN.
- Defined: an 8'h0A received when the last byte accepted into the FIFO was 8'h0D is discarded at the write side. It is not counted and does not set o_Overflow. This prevents a double display clear on CRLF line endings. The "last accepted" flag resets to 0.
- Undefined: every byte is enqueued.

Decomposition:
- Package lcd_feeder_pkg: FSM state encodings (2-bit), ASCII_CR=8'h0D, ASCII_LF=8'h0A, default DEPTH/ACK_TIMEOUT constants.
- One sub-module, sync_fifo: parameterised DEPTH/width, full/empty/count, FWFT read, simultaneous push/pop.
- FSM, timeout counter, overflow flag and CRLF filter stay in the top level.

Test Plan:
- Single byte: ready held high, i_Rx_DV with 8'h41 → o_Data_Valid pulses once, 3 cycles after the strobe, o_Data_Character=8'h41; count returns to 0 once the bench drops ready for 1 cycle.
- Burst while busy: ready low, push 8'h30..8'h39 → count=10, no valid. Raise ready, with the model dropping ready 14 cycles per character → 10 pulses in order 30..39, count ends at 0.
- Overflow: ready low, push 17 bytes at DEPTH=16 → count=16, o_Overflow=1, 17th byte absent from output. i_Clear_Overflow → o_Overflow=0.
- Timeout retry: ready held high and never dropped after the valid of 8'h55 → after ACK_TIMEOUT+1 cycles 8'h55 is presented again; count stays 1.
- Reset mid-transfer: reset asserted in WAIT_ACK with count=5 → next cycle count=0, all outputs 0, FSM IDLE.
- LCD_CRLF_COLLAPSE_EN defined: push 0D,0A,0A → output 0D,0A. Undefined: output 0D,0A,0A.
